// File: rtl/esp_uart_rx_periph_pkg.sv
// Shared definitions for the ESP8266 UART receive peripheral:
// bus register map, status bit layout and receiver state encoding.
package esp_uart_rx_periph_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_CLR    = 4'h2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_COUNT_HI  = 4;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/esp_uart_rx.sv
// UART deserialiser: 2-flop synchroniser, single baud counter and an
// IDLE/START/DATA/STOP FSM producing one-cycle byte and framing-error pulses.
module esp_uart_rx
    import esp_uart_rx_periph_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       i_clk,
    input  logic       i_sys_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err_pulse
);

    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(DIV / 2 - 1);

    logic            r_sync1, r_sync2, r_rx_prev;
    rx_state_t       r_state, w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid, r_ferr;
    logic            w_fall, w_cnt_clr, w_bit_clr, w_shift_en, w_valid, w_ferr;

    // Synchroniser chain plus one extra stage for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_sys_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    // Receiver state register
    always_ff @(posedge i_clk) begin
        if (i_sys_rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_nx = r_state;
        w_cnt_clr  = 1'b0;
        w_bit_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_valid    = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_fall) begin
                    w_state_nx = RX_START;
                end else begin
                    w_state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_clr = 1'b1;
                    w_bit_clr = 1'b1;
                    if (r_sync2) begin
                        w_state_nx = RX_IDLE;
                    end else begin
                        w_state_nx = RX_DATA;
                    end
                end else begin
                    w_state_nx = RX_START;
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_shift_en = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nx = RX_STOP;
                    end else begin
                        w_state_nx = RX_DATA;
                    end
                end else begin
                    w_state_nx = RX_DATA;
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = RX_IDLE;
                    if (r_sync2) begin
                        w_valid = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end else begin
                    w_state_nx = RX_STOP;
                end
            end
            default: begin
                w_state_nx = RX_IDLE;
                w_cnt_clr  = 1'b1;
            end
        endcase
    end

    // Baud counter, wraps at DIV-1 so successive data bits land mid-bit
    always_ff @(posedge i_clk) begin
        if (i_sys_rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Shift register, bit index and registered output pulses
    always_ff @(posedge i_clk) begin
        if (i_sys_rst) begin
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
            if (w_bit_clr) begin
                r_bit <= 3'd0;
            end else if (w_shift_en) begin
                r_shift[r_bit] <= r_sync2;
                r_bit          <= r_bit + 3'd1;
            end
        end
    end

    assign o_byte            = r_shift;
    assign o_byte_valid      = r_valid;
    assign o_frame_err_pulse = r_ferr;

endmodule

// File: rtl/esp_uart_rx_periph.sv
// J1-bus peripheral for ESP8266 -> J1 data: UART receiver feeding a byte
// FIFO, with data/status/clear registers on the shared addr/cs/rd/wr bus.
module esp_uart_rx_periph
    import esp_uart_rx_periph_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [3:0]  addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        rx,
    output logic        rx_irq
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun, r_frame_err, r_rd_prev, r_irq;
    logic [15:0]   r_d_out;
    logic [7:0]    w_byte;
    logic          w_byte_valid, w_ferr_pulse;
    logic          w_empty, w_full, w_count_hi, w_rd_edge;
    logic          w_pop, w_push, w_ovr_set, w_clr;
    logic [15:0]   w_status, w_rd_data;

    esp_uart_rx #(.DIV(DIV)) u_rx (
        .i_clk             (clk),
        .i_sys_rst         (sys_rst),
        .i_rx              (rx),
        .o_byte            (w_byte),
        .o_byte_valid      (w_byte_valid),
        .o_frame_err_pulse (w_ferr_pulse)
    );

    assign w_empty    = (r_count == CW'(0));
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_count_hi = (r_count >= CW'(FIFO_DEPTH / 2));
    // One action per bus access: only the first cycle of a held cs&rd counts
    assign w_rd_edge  = cs & rd & ~r_rd_prev;
    assign w_pop      = w_rd_edge & (addr == ADDR_DATA) & ~w_empty;
    assign w_push     = w_byte_valid & (~w_full | w_pop);
    assign w_ovr_set  = w_byte_valid & w_full & ~w_pop;
    assign w_clr      = cs & wr & (addr == ADDR_CLR);

    // Status word assembly
    always_comb begin
        w_status               = 16'h0000;
        w_status[ST_NOT_EMPTY] = ~w_empty;
        w_status[ST_FULL]      = w_full;
        w_status[ST_FRAME_ERR] = r_frame_err;
        w_status[ST_OVERRUN]   = r_overrun;
        w_status[ST_COUNT_HI]  = w_count_hi;
    end

    // Read data multiplexer
    always_comb begin
        w_rd_data = 16'h0000;
        case (addr)
            ADDR_DATA: begin
                if (w_empty) begin
                    w_rd_data = 16'h0000;
                end else begin
                    w_rd_data = {8'h00, r_mem[r_rd_ptr]};
                end
            end
            ADDR_STATUS: w_rd_data = w_status;
            default:     w_rd_data = 16'h0000;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_ferr_pulse) begin
                r_frame_err <= 1'b1;
            end else if (w_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    // Registered bus read data and interrupt
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_rd_prev <= 1'b0;
            r_d_out   <= 16'h0000;
            r_irq     <= 1'b0;
        end else begin
            r_rd_prev <= cs & rd;
            r_irq     <= ~w_empty;
            if (w_rd_edge) begin
                r_d_out <= w_rd_data;
            end
        end
    end

    assign d_out  = r_d_out;
    assign rx_irq = r_irq;

endmodule

// File: tb/tb_esp_uart_rx_periph.sv
// Self-checking bench for esp_uart_rx_periph with DIV=10 and a 4-entry FIFO;
// a byte scoreboard queue models the FIFO and sticky flags.
module tb_esp_uart_rx_periph;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  addr = 4'h0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic        rx = 1'b1;
    logic        rx_irq;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;

    esp_uart_rx_periph #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .addr    (addr),
        .cs      (cs),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .rx      (rx),
        .rx_irq  (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] exp_status();
        int c;
        c = exp_q.size();
        return {11'd0, (c >= DEPTH / 2), m_ovr, m_ferr, (c == DEPTH), (c != 0)};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = stop_bit;
        tick(10);
        rx = 1'b1;
        if (stop_bit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        tick(4);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
        addr = a; cs = 1'b1; rd = 1'b1;
        tick(1);
        v = d_out;
        cs = 1'b0; rd = 1'b0;
        tick(1);
    endtask

    task automatic bus_write(input logic [3:0] a);
        addr = a; cs = 1'b1; wr = 1'b1;
        tick(1);
        cs = 1'b0; wr = 1'b0;
        if (a == 4'h2) begin
            m_ovr = 1'b0;
            m_ferr = 1'b0;
        end
        tick(1);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        sys_rst = 1'b1;
        tick(3);
        n_checks++;
        if (d_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got %h want 0000", d_out); end
        n_checks++;
        if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", rx_irq); end
        sys_rst = 1'b0;
        tick(2);
        bus_read(4'h1, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_status got %h want 0000", v); end
    endtask

    task automatic test_single_byte();
        logic [15:0] v, e;
        send_frame(8'hA5, 1'b1);
        n_checks++;
        if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL single_irq_set got %b want 1", rx_irq); end
        bus_read(4'h1, v);
        n_checks++;
        if (v !== 16'h0001) begin n_fail++; $display("FAIL single_status got %h want 0001", v); end
        bus_read(4'h0, v);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL single_data got %h want %h", v, e); end
        bus_read(4'h1, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL single_status_empty got %h want 0000", v); end
        n_checks++;
        if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clr got %b want 0", rx_irq); end
    endtask

    task automatic test_held_read();
        logic [15:0] v, e, v1, v2, v3;
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h33, 1'b1);
        addr = 4'h0; cs = 1'b1; rd = 1'b1;
        tick(1); v1 = d_out;
        tick(1); v2 = d_out;
        tick(1); v3 = d_out;
        cs = 1'b0; rd = 1'b0;
        tick(1);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v1 !== e || v2 !== e || v3 !== e) begin
            n_fail++; $display("FAIL held_read got %h %h %h want %h", v1, v2, v3, e);
        end
        bus_read(4'h0, v);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL held_second got %h want %h", v, e); end
        bus_read(4'h1, v);
        e = exp_status();
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL held_status got %h want %h", v, e); end
        bus_read(4'h0, v);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL held_drain got %h want %h", v, e); end
    endtask

    task automatic test_overrun();
        logic [15:0] v, e;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        bus_read(4'h1, v);
        e = exp_status();
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL ovr_status got %h want %h", v, e); end
        for (int i = 0; i < 5; i++) begin
            bus_read(4'h0, v);
            if (exp_q.size() == 0) e = 16'h0000;
            else e = {8'h00, exp_q.pop_front()};
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL ovr_data%0d got %h want %h", i, v, e); end
        end
        bus_write(4'h2);
        bus_read(4'h1, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL ovr_cleared got %h want 0000", v); end
    endtask

    task automatic test_frame_err();
        logic [15:0] v, e;
        send_frame(8'h55, 1'b0);
        bus_read(4'h1, v);
        e = exp_status();
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL ferr_status got %h want %h", v, e); end
        n_checks++;
        if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL ferr_irq got %b want 0", rx_irq); end
        bus_write(4'h2);
        send_frame(8'h66, 1'b1);
        bus_read(4'h0, v);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL ferr_next_data got %h want %h", v, e); end
    endtask

    task automatic test_glitch();
        logic [15:0] v, e;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        bus_read(4'h1, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch_status got %h want 0000", v); end
        send_frame(8'h5A, 1'b1);
        bus_read(4'h0, v);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL glitch_after_data got %h want %h", v, e); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] v, e;
        logic [7:0]  b;
        b = 8'h7E;
        send_frame(8'h11, 1'b1);
        n_checks++;
        if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL midrst_irq_pre got %b want 1", rx_irq); end
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = b[4];
        tick(4);
        sys_rst = 1'b1;
        tick(1);
        n_checks++;
        if (d_out !== 16'h0000 || rx_irq !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs got %h/%b want 0000/0", d_out, rx_irq);
        end
        rx = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        exp_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        tick(110);
        bus_read(4'h1, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL midrst_status got %h want 0000", v); end
        send_frame(8'h42, 1'b1);
        bus_read(4'h0, v);
        e = {8'h00, exp_q.pop_front()};
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL midrst_data got %h want %h", v, e); end
        bus_read(4'h0, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL midrst_empty got %h want 0000", v); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_held_read();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
